// File: rtl/util_trafic_generator_pkt.sv
// Packetised AXI-Stream traffic generator: programmable length, gap, payload mode and round-robin tdest.
// Optional macro UTIL_TG_TUSER_EN adds m_axis_tuser carrying the packet sequence number.
module util_trafic_generator_pkt #(
    parameter int TBYTE_NUM  = 16,
    parameter int ID_WIDTH   = 5,
    parameter int DEST_WIDTH = 5,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [LEN_WIDTH-1:0]     cfg_pkt_len,
    input  logic [GAP_WIDTH-1:0]     cfg_gap,
    input  logic [1:0]               cfg_mode,
    input  logic [31:0]              cfg_pattern,
    input  logic [DEST_WIDTH-1:0]    cfg_dest_num,
    output logic                     busy,
    output logic [31:0]              pkt_cnt,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [TBYTE_NUM*8-1:0]   m_axis_tdata,
    output logic [TBYTE_NUM-1:0]     m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [ID_WIDTH-1:0]      m_axis_tid,
    output logic [DEST_WIDTH-1:0]    m_axis_tdest
`ifdef UTIL_TG_TUSER_EN
    ,
    output logic [31:0]              m_axis_tuser
`endif
);

    localparam int DW    = TBYTE_NUM * 8;
    localparam int KB    = $clog2(TBYTE_NUM);
    localparam int LANES = TBYTE_NUM / 4;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    beat_q, beat_d, last_beat_q, last_beat_d;
    logic [KB-1:0]           rem_q, rem_d;
    logic [1:0]              mode_q, mode_d;
    logic [31:0]             pattern_q, pattern_d, lfsr_q, lfsr_d, pkt_cnt_q, pkt_cnt_d;
    logic [GAP_WIDTH-1:0]    gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [DEST_WIDTH-1:0]   dest_num_q, dest_num_d, tdest_q, tdest_d, dest_idx_q, dest_idx_d;
    logic [DEST_WIDTH:0]     dest_inc;
    logic [LEN_WIDTH-1:0]    len_eff;
    logic [31:0]             lfsr_next;
    logic                    start, valid, hs, is_last;
    logic [7:0]              cnt_base;
    logic [DW-1:0]           cnt_data, gen_data;
    logic [TBYTE_NUM-1:0]    keep_last;

    assign len_eff   = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
    assign valid     = (state_q == S_SEND);
    assign hs        = valid & m_axis_tready;
    assign is_last   = (beat_q == last_beat_q);
    // Fibonacci LFSR, taps 32,22,2,1
    assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    assign dest_inc  = {1'b0, tdest_q} + (DEST_WIDTH+1)'(1);

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        last_beat_d = last_beat_q;
        rem_d       = rem_q;
        mode_d      = mode_q;
        pattern_d   = pattern_q;
        lfsr_d      = lfsr_q;
        pkt_cnt_d   = pkt_cnt_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        dest_num_d  = dest_num_q;
        tdest_d     = tdest_q;
        dest_idx_d  = dest_idx_q;
        start       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) start = 1'b1;
            end
            S_SEND: begin
                if (hs) begin
                    lfsr_d = lfsr_next;
                    if (is_last) begin
                        pkt_cnt_d  = pkt_cnt_q + 32'd1;
                        dest_idx_d = (dest_inc >= {1'b0, dest_num_q}) ? '0 : dest_inc[DEST_WIDTH-1:0];
                        if (!en)                state_d = S_IDLE;
                        else if (gap_q == '0)   start   = 1'b1;
                        else begin
                            state_d   = S_GAP;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                    if (en) start   = 1'b1;
                    else    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Packet start: latch the whole configuration so mid-packet changes are ignored
        if (start) begin
            state_d     = S_SEND;
            beat_d      = '0;
            last_beat_d = (len_eff - LEN_WIDTH'(1)) >> KB;
            rem_d       = len_eff[KB-1:0];
            mode_d      = cfg_mode;
            pattern_d   = cfg_pattern;
            lfsr_d      = (cfg_pattern == '0) ? 32'd1 : cfg_pattern;
            gap_d       = cfg_gap;
            dest_num_d  = cfg_dest_num;
            tdest_d     = (dest_idx_d >= cfg_dest_num) ? '0 : dest_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            last_beat_q <= '0;
            rem_q       <= '0;
            mode_q      <= '0;
            pattern_q   <= '0;
            lfsr_q      <= '0;
            pkt_cnt_q   <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            dest_num_q  <= '0;
            tdest_q     <= '0;
            dest_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            last_beat_q <= last_beat_d;
            rem_q       <= rem_d;
            mode_q      <= mode_d;
            pattern_q   <= pattern_d;
            lfsr_q      <= lfsr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            dest_num_q  <= dest_num_d;
            tdest_q     <= tdest_d;
            dest_idx_q  <= dest_idx_d;
        end
    end

    assign cnt_base = 8'({beat_q, {KB{1'b0}}});

    generate
        for (genvar gi = 0; gi < TBYTE_NUM; gi++) begin : g_cnt
            assign cnt_data[gi*8 +: 8] = cnt_base + 8'(gi);
        end
    endgenerate

    always_comb begin
        gen_data = {LANES{pattern_q}};
        case (mode_q)
            2'd0:    gen_data = cnt_data;
            2'd1:    gen_data = {LANES{lfsr_q}};
            default: gen_data = {LANES{pattern_q}};
        endcase
    end

    assign keep_last     = (rem_q == '0) ? '1 : ~({TBYTE_NUM{1'b1}} << rem_q);
    assign busy          = (state_q != S_IDLE);
    assign pkt_cnt       = pkt_cnt_q;
    assign m_axis_tvalid = valid;
    assign m_axis_tdata  = valid ? gen_data : '0;
    assign m_axis_tkeep  = valid ? (is_last ? keep_last : '1) : '0;
    assign m_axis_tlast  = valid & is_last;
    assign m_axis_tid    = '0;
    assign m_axis_tdest  = valid ? tdest_q : '0;

`ifdef UTIL_TG_TUSER_EN
    logic [31:0] seq_q;
    always_ff @(posedge clk) begin
        if (rst)        seq_q <= '0;
        else if (start) seq_q <= pkt_cnt_d;
    end
    assign m_axis_tuser = seq_q;
`else
    // Sequence tagging disabled: no tuser port, no sequence register.
`endif

endmodule

// File: tb/tb_util_trafic_generator_pkt.sv
// Directed + randomized bench for util_trafic_generator_pkt against a packet-level reference model.
module tb_util_trafic_generator_pkt;
    localparam int TB = 16;

    logic         clk = 1'b0;
    logic         rst, en;
    logic [15:0]  cfg_pkt_len, cfg_gap;
    logic [1:0]   cfg_mode;
    logic [31:0]  cfg_pattern;
    logic [4:0]   cfg_dest_num;
    logic         busy;
    logic [31:0]  pkt_cnt;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic [4:0]   m_axis_tid, m_axis_tdest;
`ifdef UTIL_TG_TUSER_EN
    logic [31:0]  m_axis_tuser;
`endif

    int checks = 0, failures = 0, exp_pkt = 0;
    int w;

    util_trafic_generator_pkt dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_pkt_len(cfg_pkt_len), .cfg_gap(cfg_gap), .cfg_mode(cfg_mode),
        .cfg_pattern(cfg_pattern), .cfg_dest_num(cfg_dest_num),
        .busy(busy), .pkt_cnt(pkt_cnt),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest)
`ifdef UTIL_TG_TUSER_EN
        , .m_axis_tuser(m_axis_tuser)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One step of the x^32+x^22+x^2+x+1 sequence, shifting towards the MSB.
    function automatic logic [31:0] prbs_step(input logic [31:0] s);
        int   taps [4] = '{32, 22, 2, 1};
        logic fb = 1'b0;
        foreach (taps[k]) fb ^= s[taps[k]-1];
        return {s[30:0], fb};
    endfunction

    function automatic logic [127:0] model_beat(input int mode, input logic [31:0] pat,
                                                input logic [31:0] lf, input int b);
        logic [127:0] d;
        for (int i = 0; i < TB; i++) d[i*8 +: 8] = 8'((b * TB + i) % 256);
        if (mode == 1)      d = {4{lf}};
        else if (mode >= 2) d = {4{pat}};
        return d;
    endfunction

    // Observes one packet beat by beat, checking every presented beat against the model.
    task automatic collect(input int L, input int mode, input logic [31:0] pat, input int exp_dest,
                           input int drop_at, input int stop_after, input bit rnd_ready,
                           input bit scramble, output int waited);
        int le, nb, rem, b, guard, lim, seq;
        logic [31:0]  lf;
        logic [127:0] ed, held;
        logic [15:0]  ek;
        bit stalled;
        le = (L == 0) ? 1 : L;
        nb = (le + TB - 1) / TB;
        rem = le % TB;
        lim = (stop_after < nb) ? stop_after : nb;
        lf = (pat == 0) ? 32'd1 : pat;
        b = 0; guard = 0; stalled = 0; waited = 0; seq = exp_pkt; held = '0;
        while (b < lim && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (!m_axis_tvalid && b == 0 && !stalled) begin
                waited++;
                continue;
            end
            if (drop_at >= 0 && b >= drop_at) en = 1'b0;
            chk("tvalid", 128'(m_axis_tvalid), 128'(1));
            ed = model_beat(mode, pat, lf, b);
            ek = (b == nb - 1 && rem != 0) ? 16'((1 << rem) - 1) : 16'hFFFF;
            if (stalled) chk("stall_hold", m_axis_tdata, held);
            chk("tdata", m_axis_tdata, ed);
            chk("tkeep", 128'(m_axis_tkeep), 128'(ek));
            chk("tlast", 128'(m_axis_tlast), 128'(b == nb - 1));
            chk("tdest", 128'(m_axis_tdest), 128'(exp_dest));
`ifdef UTIL_TG_TUSER_EN
            chk("tuser", 128'(m_axis_tuser), 128'(seq));
`endif
            m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tready) begin
                lf = prbs_step(lf);
                b++;
                stalled = 0;
            end else begin
                stalled = 1;
                held = m_axis_tdata;
            end
            if (scramble) begin
                cfg_pkt_len = 16'($urandom);
                cfg_mode    = 2'($urandom);
                cfg_pattern = $urandom;
            end
        end
        chk("beats", 128'(b), 128'(lim));
        if (b == nb) exp_pkt++;
        $display("pkt L=%0d mode=%0d pat=%08h beats=%0d/%0d dest=%0d waited=%0d",
                 L, mode, pat, b, nb, exp_dest, waited);
    endtask

    task automatic set_cfg(input int L, input int gap, input int mode, input logic [31:0] pat,
                           input int dn);
        cfg_pkt_len  = 16'(L);
        cfg_gap      = 16'(gap);
        cfg_mode     = 2'(mode);
        cfg_pattern  = pat;
        cfg_dest_num = 5'(dn);
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_pkt_cnt"}, 128'(pkt_cnt), 128'(exp_pkt));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int L, mode;
        logic [31:0] pat;
        rst = 1'b1; en = 1'b0; m_axis_tready = 1'b0;
        set_cfg(0, 0, 0, 32'h0, 0);
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
        chk("rst_tdata", m_axis_tdata, 128'(0));
        chk("rst_tkeep", 128'(m_axis_tkeep), 128'(0));
        chk("rst_tlast", 128'(m_axis_tlast), 128'(0));
        chk("rst_tdest", 128'(m_axis_tdest), 128'(0));
        chk("rst_tid", 128'(m_axis_tid), 128'(0));
        rst = 1'b0;

        // 40-byte counter packet, single-cycle enable pulse, config scrambled mid-packet
        set_cfg(40, 0, 0, 32'h0, 0);
        en = 1'b1;
        collect(40, 0, 32'h0, 0, 0, 99, 0, 1, w);
        chk("t1_latency", 128'(w), 128'(0));
        chk_idle("t1");

        // 16-byte packets with a 3-cycle gap, enable held
        set_cfg(16, 3, 0, 32'h0, 0);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            collect(16, 0, 32'h0, 0, (k == 3) ? 0 : -1, 99, 0, 0, w);
            chk("t2_gap", 128'(w), 128'((k == 0) ? 0 : 3));
        end
        chk_idle("t2");

        // PRBS, seed 1 and seed 0, random backpressure
        set_cfg(64, 0, 1, 32'h1, 0);
        en = 1'b1;
        collect(64, 1, 32'h1, 0, 0, 99, 1, 1, w);
        chk_idle("t3a");
        set_cfg(50, 0, 1, 32'h0, 0);
        en = 1'b1;
        collect(50, 1, 32'h0, 0, 0, 99, 1, 1, w);
        chk_idle("t3b");

        // Round-robin tdest over 3 destinations, back-to-back packets
        set_cfg(20, 0, 0, 32'h0, 3);
        en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            collect(20, 0, 32'h0, k % 3, (k == 6) ? 0 : -1, 99, 1, 0, w);
            chk("t4_no_bubble", 128'(w), 128'(0));
        end
        chk_idle("t4");

        // en dropped at beat1 of a 4-beat packet: packet completes
        set_cfg(64, 0, 0, 32'h0, 0);
        en = 1'b1;
        collect(64, 0, 32'h0, 0, 1, 99, 0, 0, w);
        chk_idle("t5a");

        // rst while beat2 of a later packet is presented
        set_cfg(64, 0, 1, 32'h1234_5678, 0);
        en = 1'b1;
        collect(64, 1, 32'h1234_5678, 0, 0, 2, 1, 0, w);
        @(negedge clk);
        chk("t5_beat2_valid", 128'(m_axis_tvalid), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pkt = 0;
        chk("t5_rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("t5_rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
        chk("t5_rst_busy", 128'(busy), 128'(0));

        // Zero length acts as one byte; fixed and reserved modes
        set_cfg(0, 0, 2, 32'hDEAD_BEEF, 0);
        en = 1'b1;
        collect(0, 2, 32'hDEAD_BEEF, 0, 0, 99, 0, 0, w);
        chk_idle("t6a");
        set_cfg(0, 0, 3, 32'hCAFE_F00D, 0);
        en = 1'b1;
        collect(0, 3, 32'hCAFE_F00D, 0, 0, 99, 1, 0, w);
        chk_idle("t6b");

        // Randomized packets
        for (int k = 0; k < 8; k++) begin
            L    = int'($urandom_range(1, 100));
            mode = int'($urandom_range(0, 3));
            pat  = (k == 0) ? 32'h0 : $urandom;
            set_cfg(L, int'($urandom_range(0, 4)), mode, pat, 0);
            en = 1'b1;
            collect(L, mode, pat, 0, 0, 99, 1, 1, w);
            chk("rnd_latency", 128'(w), 128'(0));
            chk_idle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
